// File: rtl/oam_dma_if.sv
// Signal bundle joining the OAM DMA engine to the FF46 register decoder,
// the source memory and the PPU OAM write port.
interface oam_dma_if;
    logic        reg_write;
    logic [7:0]  reg_d_wr;
    logic [7:0]  reg_d_rd;
    logic        active;
    logic [15:0] src_addr;
    logic [7:0]  src_d_rd;
    logic [7:0]  oam_addr;
    logic        oam_write;
    logic [7:0]  oam_d_wr;
    logic        done;

    // The DMA engine is the slave of the register decoder and the master of memory traffic.
    modport slave (
        input  reg_write, reg_d_wr, src_d_rd,
        output reg_d_rd, active, src_addr, oam_addr, oam_write, oam_d_wr, done
    );

    modport master (
        output reg_write, reg_d_wr, src_d_rd,
        input  reg_d_rd, active, src_addr, oam_addr, oam_write, oam_d_wr, done
    );
endinterface

// File: rtl/oam_dma.sv
// OAM DMA engine behind FF46: copies LEN bytes from page {FF46,8'h00}
// into PPU OAM through a one-stage read pipeline (synchronous source memory).
module oam_dma #(
    parameter int LEN         = 160,
    parameter int START_DELAY = 1
) (
    input  logic     clk,
    input  logic     rst,
    oam_dma_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DELAY, XFER, DRAIN} state_e;

    localparam int              CW         = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
    localparam logic [CW-1:0]   DELAY_INIT = (START_DELAY > 0) ? CW'(START_DELAY - 1) : '0;
    localparam logic [7:0]      LAST_IDX   = 8'(LEN - 1);

    state_e         state_q;
    logic [7:0]     reg_q;
    logic           active_q;
    logic           done_q;
    logic [CW-1:0]  cnt_q;
    logic [7:0]     idx_q;
    logic [7:0]     pipe_idx_q;
    logic           valid_q;
    logic [15:0]    src_addr_q;
    logic [7:0]     wr_page;
    logic [7:0]     cur_page;

    // Pages E0..FF are echo RAM and alias onto C0..DF.
    function automatic logic [7:0] fold_page(input logic [7:0] page);
        return (page >= 8'hE0) ? page - 8'h20 : page;
    endfunction

    assign wr_page  = fold_page(bus.reg_d_wr);
    assign cur_page = fold_page(reg_q);

    // NOTE: every register below is updated with <= so all of them see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            reg_q      <= 8'hFF;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
            cnt_q      <= '0;
            idx_q      <= '0;
            pipe_idx_q <= '0;
            valid_q    <= 1'b0;
            src_addr_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (bus.reg_write) begin
                // A write always restarts from index 0; any byte still in flight is dropped.
                reg_q    <= bus.reg_d_wr;
                idx_q    <= '0;
                valid_q  <= 1'b0;
                active_q <= 1'b1;
                if (START_DELAY == 0) begin
                    state_q    <= XFER;
                    src_addr_q <= {wr_page, 8'h00};
                end else begin
                    state_q <= DELAY;
                    cnt_q   <= DELAY_INIT;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        valid_q <= 1'b0;
                    end
                    DELAY: begin
                        if (cnt_q == '0) begin
                            state_q    <= XFER;
                            idx_q      <= '0;
                            src_addr_q <= {cur_page, 8'h00};
                        end else begin
                            cnt_q <= cnt_q - CW'(1);
                        end
                    end
                    XFER: begin
                        valid_q    <= 1'b1;
                        pipe_idx_q <= idx_q;
                        idx_q      <= idx_q + 8'd1;
                        if (idx_q == LAST_IDX) begin
                            state_q <= DRAIN;
                        end else begin
                            src_addr_q[7:0] <= idx_q + 8'd1;
                        end
                    end
                    DRAIN: begin
                        state_q  <= IDLE;
                        valid_q  <= 1'b0;
                        active_q <= 1'b0;
                        done_q   <= 1'b1;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // The write strobe is masked by rst so an abandoned transfer never lands a byte.
    assign bus.oam_write = valid_q & ~rst;
    assign bus.oam_addr  = pipe_idx_q;
    assign bus.oam_d_wr  = bus.oam_write ? bus.src_d_rd : 8'h00;
    assign bus.reg_d_rd  = reg_q;
    assign bus.active    = active_q;
    assign bus.src_addr  = src_addr_q;
    assign bus.done      = done_q;
endmodule

// File: doc/oam_dma.md
Name: oam_dma

Overview:
- OAM DMA engine behind the FF46 register.
- A CPU write to FF46 starts a copy of LEN bytes from source page {data,8'h00} into sprite attribute memory (OAM) inside the PPU.
- During the copy, the block drives the source-side bus and the PPU OAM write port, and raises `active` so the top-level decoder restricts the CPU to HRAM.
- It sits on the CPU bus between the address decoder (upstream) and the PPU OAM port (downstream).

Parameters:
- LEN, 160: bytes transferred per DMA (OAM indices 0..LEN-1); LEN <= 256.
- START_DELAY, 1: idle cycles between the register write and the first source read; 0 is legal.

Ports:
- clk  input  1  block clock (CPU clock domain).
- rst  input  1  reset; synchronous, active-high.
- reg_write  input  1  FF46 write strobe, already decoded by the top level; sampled on posedge clk.
- reg_d_wr  input  8  FF46 write data (source page).
- reg_d_rd  output  8  FF46 readback: last written value.
- active  output  1  DMA in progress; the bus arbiter gives the source bus to this block.
- src_addr  output  16  source read address.
- src_d_rd  input  8  source data; valid the cycle after src_addr is presented (synchronous memories).
- oam_addr  output  8  OAM byte index.
- oam_write  output  1  OAM write enable.
- oam_d_wr  output  8  OAM write data.
- done  output  1  one-cycle pulse when the final byte has been written.

Behaviour:
- Reset values (applied on posedge clk with rst=1, and also mid-transfer):
  - state=IDLE, reg_d_rd=8'hFF, active=0, oam_write=0, done=0, idx=0, pipeline valid=0.
  - src_addr=16'h0000, oam_addr=0, oam_d_wr=0.
  - A transfer in flight is abandoned; no further OAM writes occur.
- States: IDLE, DELAY, XFER, DRAIN.
- Register write (any state, reg_write=1 at edge E0):
  - reg_d_rd <= reg_d_wr.
  - idx <= 0; pipeline valid <= 0. Any byte in flight from an old transfer is dropped and never written.
  - Next state is DELAY with counter=START_DELAY-1, or XFER if START_DELAY=0.
  - A restart during an active transfer therefore begins again from index 0 with the new page.
- Page fold: effective page = reg_d_rd, except that 8'hE0..8'hFF map to page-8'h20 (echo RAM). Example: 8'hFE -> 8'hDE.
- DELAY:
  - active=1, no bus access.
  - Counter decrements each edge; at 0 the next edge enters XFER with idx=0.
- XFER:
  - active=1; src_addr={effective_page, idx}, registered.
  - Each edge: pipeline valid<=1, pipe_idx<=idx, idx<=idx+1.
  - On the edge where idx==LEN-1, go to DRAIN.
- OAM write (combinational from the pipeline stage):
  - oam_write=valid & ~rst; oam_addr=pipe_idx; oam_d_wr=src_d_rd.
  - Byte i is written exactly one cycle after src_addr presented index i.
- DRAIN:
  - active=1; the last byte (index LEN-1) is written this cycle.
  - Next edge: IDLE, valid<=0, done<=1 for exactly one cycle.
- IDLE: active=0, oam_write=0; src_addr holds its last value (don't-care).
- Timing with defaults: active is high for exactly START_DELAY+LEN+1 = 162 cycles, starting the cycle after E0. Exactly LEN OAM writes occur, at indices 0..159 in ascending order, with no gaps.
- Simultaneous reg_write in the DRAIN cycle: the last OAM write still occurs that cycle, then the restart takes effect. done is not pulsed.
- Simultaneous rst and reg_write: rst wins; reg_d_rd=8'hFF.
- idx arithmetic: 8-bit. With LEN<=256, idx never wraps within a transfer and src_addr low byte never exceeds LEN-1.
- reg_d_rd is readable at all times. This block does not disable or alter it during DMA; bus gating is external.

Test Plan:
- Basic copy: preload source 16'hC000+i = i^8'h5A; write 8'hC0 -> active is high 162 cycles; 160 OAM writes, where OAM[i] = i^8'h5A and OAM[i] is written 1 cycle after src_addr=16'hC000+i; done pulses once; reg_d_rd=8'hC0.
- Echo fold: write 8'hE3 -> src_addr runs 16'hC300..16'hC39F; reg_d_rd=8'hE3.
- Restart: write 8'h80, then write 8'h90 during the 50th XFER cycle -> no OAM write from page 8'h80 occurs after the restart edge; OAM indices 0..159 rewritten from page 8'h90; exactly one done pulse; active stays high continuously.
- Reset mid-transfer: assert rst during byte 100 -> in the following cycle active=0, oam_write=0, reg_d_rd=8'hFF; no done pulse; a subsequent write of 8'hD0 completes a full 160-byte copy.
- START_DELAY=0 and START_DELAY=3 builds: the first src_addr appears 1 and 4 cycles after E0 respectively; active lasts 161 and 164 cycles.
- Write during DRAIN: the final OAM write (index 159) still occurs; no done pulse; the new transfer completes normally.
